pcap_mem_writer: RTL and testbench
==================================

# pcap_mem_writer

Downstream consumer of the narrow packed-byte FIFO feeding the replay engine. Pops 144-bit words (16 lanes of {strb,byte}) plus a queue id, parses the two-word per-packet header to learn the packet length, and writes header and payload words into that queue's memory region. Whole packets that do not fit in the remaining region are dropped. Per-queue write pointers, packet counters and drop counters are exported for the register block.

## Interface
- FIFO_DATA_WIDTH, 144, word width; 16 lanes × 9 bits, lane i = {strb bit 9i+8, data bits 9i+7:9i}
- NUM_QUEUES, 4, number of queues/regions
- NUM_QUEUES_BITS, log2(NUM_QUEUES), qid width
- ADDR_WIDTH, 19, memory word-address width
- LEN_POS, 0, bit offset of the 16-bit byte length within the header low word

Ports:
- axi_aclk  in  1  sole clock (memory-side domain)
- axi_aresetn  in  1  asynchronous, active-low reset
- sw_rst  in  1  synchronous soft reset, same effect as reset
- fifo_dout  in  FIFO_DATA_WIDTH  FWFT head word, valid while !fifo_empty
- fifo_dout_qid  in  NUM_QUEUES_BITS  qid of head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop head word
- mem_wr_en  out  1  registered write strobe
- mem_wr_addr  out  ADDR_WIDTH  registered word address
- mem_wr_data  out  FIFO_DATA_WIDTH  registered word
- mem_wr_full  in  1  memory write queue has fewer than 3 free slots
- wr_enable  in  1  sampled in HDR_HI only; 0 holds off new packets
- q_base_addr  in  NUM_QUEUES*ADDR_WIDTH  region start per queue
- q_high_addr  in  NUM_QUEUES*ADDR_WIDTH  region last valid address per queue
- q_ptr_clr  in  NUM_QUEUES  per-queue pointer reload to base
- q_wr_ptr  out  NUM_QUEUES*ADDR_WIDTH  next write address per queue
- q_pkt_cnt  out  NUM_QUEUES*32  packets stored
- q_drop_cnt  out  NUM_QUEUES*32  packets dropped

## Operation
- Word order per packet: header-high (all data 0), header-low (tuser[127:0]), then 2 words per 32-byte beat, high half first.
- States: HDR_HI → HDR_LO → WR_HI → WR_LO → DATA → HDR_HI; HDR_LO → DROP → HDR_HI.
- HDR_HI: pop when !fifo_empty && wr_enable; latch word into hold_hi, latch qid.
- HDR_LO: pop when !fifo_empty; latch hold_lo; len = data bytes at lanes LEN_POS/8, +1 (little-endian); beats = ceil(len/32), len 0 → 1 beat; words = 2 + 2·beats (13-bit).
- Fit test in ADDR_WIDTH+1 bits: ptr + words − 1 ≤ high. Pass → WR_HI; fail → DROP with remaining = 2·beats, drop_cnt +1.
- WR_HI/WR_LO: write hold_hi, hold_lo at ptr, ptr+1 when !mem_wr_full; no pops.
- DATA: pop and write one word per cycle when !fifo_empty && !mem_wr_full; after last word pkt_cnt +1, → HDR_HI.
- DROP: pop when !fifo_empty regardless of mem_wr_full; no writes; → HDR_HI after last word.
- ptr increments per write, never wraps; q_ptr_clr[q], or config write, reloads base; clr in same cycle as write to q wins over increment.
- Counters 32-bit, wrap at 2^32.

## Timing
- Reset (async or sw_rst): state HDR_HI, fifo_rd_en 0, mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0, q_wr_ptr = q_base_addr, counters 0.
- fifo_rd_en is combinational from state, fifo_empty, mem_wr_full.
- mem_wr_* registered: data popped in cycle n appears at cycle n+1.
- Throughput: packet of B beats takes 2B+4 cycles with no stalls; DROP takes 2B+2.
- Reset mid-packet discards partial state; upstream resets together, so alignment holds.

## Structure
- Shared package: LANES=16, LANE_BITS=9, BEAT_BYTES=32, state encoding, lane-extract function.
- One sub-module: pcap_mem_qptr_bank (per-queue pointer, pkt/drop counters, clear/increment arbitration).

## Test plan
- q0 base 0x100, high 0x1FF, 64-byte packet → 6 writes at 0x100–0x105, ptr 0x106, pkt_cnt[0]=1.
- Packet len 33 on q2 → beats 2, 6 writes; len 0 → 4 writes.
- q1 with 4 free words, 64-byte packet → 0 writes, 6 pops, drop_cnt[1]=1, ptr unchanged; next 1-byte packet fits (4 writes).
- mem_wr_full toggled every other cycle during DATA → no lost or duplicated words, addresses contiguous.
- Interleaved q0/q3 packets back-to-back → each lands in own region; counters 1 each.
- axi_aresetn low mid-DATA → all outputs reset values next cycle; clean packet after release stored correctly.

Source files
------------

// File: rtl/pcap_mem_writer_pkg.sv
// pcap_mem_writer_pkg
// Shared definitions for the packed-byte FIFO to memory writer:
//   - lane geometry of a FIFO word (16 lanes of {strb, byte})
//   - replay beat size in bytes
//   - writer FSM state encoding and write-data source select
//   - lane_byte(): pulls the data byte out of one lane of a FIFO word
package pcap_mem_writer_pkg;

  localparam int LANES      = 16;
  localparam int LANE_BITS  = 9;
  localparam int BEAT_BYTES = 32;
  localparam int WORD_BITS  = LANES * LANE_BITS;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_WR_HI  = 3'd2,
    ST_WR_LO  = 3'd3,
    ST_DATA   = 3'd4,
    ST_DROP   = 3'd5
  } wr_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD_HI = 2'd0,
    SEL_HOLD_LO = 2'd1,
    SEL_FIFO    = 2'd2
  } wr_sel_t;

  // Data byte of a lane; the strobe bit sits above it in the 9-bit lane.
  function automatic logic [7:0] lane_byte(input logic [WORD_BITS-1:0] word,
                                           input int unsigned lane);
    return word[lane*LANE_BITS +: 8];
  endfunction

endpackage

// File: rtl/pcap_mem_qptr_bank.sv
// pcap_mem_qptr_bank
// Per-queue write pointers plus stored/dropped packet counters.
//
// Ports:
//   axi_aclk, axi_aresetn  clock, asynchronous active-low reset
//   sw_rst                 synchronous soft reset (same effect as reset)
//   q_base_addr            packed region base address per queue
//   q_ptr_clr              per-queue pointer reload to base
//   qid                    queue addressed by the strobes below
//   ptr_inc                one word written to queue qid
//   pkt_inc, drop_inc      one packet stored / dropped on queue qid
//   q_wr_ptr               packed next write address per queue
//   q_pkt_cnt, q_drop_cnt  packed 32-bit counters per queue
//
// The pointer is kept as an offset from the region base, so the exported
// pointer equals the base straight out of reset without an asynchronous
// load of a non-constant value. The register block pulses q_ptr_clr when
// it rewrites a base so the pointer restarts at the new region start.
module pcap_mem_qptr_bank #(
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = 2,
  parameter int ADDR_WIDTH      = 19
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic                             sw_rst,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_base_addr,
  input  logic [NUM_QUEUES-1:0]            q_ptr_clr,
  input  logic [NUM_QUEUES_BITS-1:0]       qid,
  input  logic                             ptr_inc,
  input  logic                             pkt_inc,
  input  logic                             drop_inc,
  output logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_wr_ptr,
  output logic [NUM_QUEUES*32-1:0]         q_pkt_cnt,
  output logic [NUM_QUEUES*32-1:0]         q_drop_cnt
);

  logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] ptr_off;
  logic [NUM_QUEUES-1:0][31:0]           pkt_cnt;
  logic [NUM_QUEUES-1:0][31:0]           drop_cnt;

  // Offset and counter update. A clear in the same cycle as a write to the
  // queue wins over the increment; counters simply wrap at 2^32.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ptr_off  <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (sw_rst) begin
      ptr_off  <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (q_ptr_clr[q]) begin
          ptr_off[q] <= '0;
        end else if (ptr_inc && (qid == NUM_QUEUES_BITS'(q))) begin
          ptr_off[q] <= ptr_off[q] + 1'b1;
        end
        if (pkt_inc && (qid == NUM_QUEUES_BITS'(q))) begin
          pkt_cnt[q] <= pkt_cnt[q] + 32'd1;
        end
        if (drop_inc && (qid == NUM_QUEUES_BITS'(q))) begin
          drop_cnt[q] <= drop_cnt[q] + 32'd1;
        end
      end
    end
  end

  // Absolute pointer is the region base plus the running offset.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_ptr
    assign q_wr_ptr[g*ADDR_WIDTH +: ADDR_WIDTH] =
      q_base_addr[g*ADDR_WIDTH +: ADDR_WIDTH] + ptr_off[g];
  end

  assign q_pkt_cnt  = pkt_cnt;
  assign q_drop_cnt = drop_cnt;

endmodule

// File: rtl/pcap_mem_writer.sv
// pcap_mem_writer
// Pops packed-byte words from the FWFT FIFO, parses the two-word packet
// header for the byte length, and writes header plus payload words into
// the region of the packet's queue. Packets that do not fit whole in the
// rest of the region are popped and discarded.
//
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   sw_rst                  synchronous soft reset
//   fifo_dout/_qid/_empty   FWFT FIFO head word, its queue id, empty flag
//   fifo_rd_en              pop head word (combinational)
//   mem_wr_en/_addr/_data   registered memory write
//   mem_wr_full             memory write queue nearly full, stall writes
//   wr_enable               0 holds off the start of new packets
//   q_base_addr/q_high_addr per-queue region first/last word address
//   q_ptr_clr               per-queue pointer reload to base
//   q_wr_ptr                per-queue next write address
//   q_pkt_cnt/q_drop_cnt    per-queue stored/dropped packet counters
module pcap_mem_writer
  import pcap_mem_writer_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = $clog2(NUM_QUEUES),
  parameter int ADDR_WIDTH      = 19,
  parameter int LEN_POS         = 0
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic                             sw_rst,
  input  logic [FIFO_DATA_WIDTH-1:0]       fifo_dout,
  input  logic [NUM_QUEUES_BITS-1:0]       fifo_dout_qid,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [FIFO_DATA_WIDTH-1:0]       mem_wr_data,
  input  logic                             mem_wr_full,
  input  logic                             wr_enable,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_base_addr,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_high_addr,
  input  logic [NUM_QUEUES-1:0]            q_ptr_clr,
  output logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_wr_ptr,
  output logic [NUM_QUEUES*32-1:0]         q_pkt_cnt,
  output logic [NUM_QUEUES*32-1:0]         q_drop_cnt
);

  localparam int LEN_LANE = LEN_POS / 8;
  localparam int EXT_W    = ADDR_WIDTH + 1;

  wr_state_t                      state, state_nxt;
  logic [FIFO_DATA_WIDTH-1:0]     hold_hi, hold_lo;
  logic [NUM_QUEUES_BITS-1:0]     cur_qid;
  logic [12:0]                    remaining;

  logic [15:0]                    pkt_len;
  logic [11:0]                    beats;
  logic [12:0]                    words;
  logic [ADDR_WIDTH-1:0]          cur_ptr, cur_high;
  logic [EXT_W-1:0]               end_addr;
  logic                           fits;

  logic                           pop, wr_now, hi_load, lo_load;
  logic                           rem_load, rem_dec, pkt_inc, drop_inc;
  wr_sel_t                        wr_sel;

  // Header-low decode: little-endian 16-bit length, rounded up to whole
  // beats (a zero-length packet still occupies one beat), then the end
  // address of the packet is tested against the region limit one bit wider
  // than the address so an overflowing sum cannot wrap into a pass.
  always_comb begin
    pkt_len  = {lane_byte(fifo_dout, LEN_LANE + 1), lane_byte(fifo_dout, LEN_LANE)};
    beats    = 12'(({1'b0, pkt_len} + 17'(BEAT_BYTES - 1)) >> $clog2(BEAT_BYTES));
    if (pkt_len == 16'd0) begin
      beats = 12'd1;
    end
    words    = 13'd2 + {beats, 1'b0};
    cur_ptr  = q_wr_ptr[cur_qid*ADDR_WIDTH +: ADDR_WIDTH];
    cur_high = q_high_addr[cur_qid*ADDR_WIDTH +: ADDR_WIDTH];
    end_addr = EXT_W'(cur_ptr) + EXT_W'(words) - EXT_W'(1);
    fits     = (end_addr <= EXT_W'(cur_high));
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_now    = 1'b0;
    wr_sel    = SEL_FIFO;
    hi_load   = 1'b0;
    lo_load   = 1'b0;
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      ST_HDR_HI: begin
        if (!fifo_empty && wr_enable) begin
          pop       = 1'b1;
          hi_load   = 1'b1;
          state_nxt = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          lo_load  = 1'b1;
          rem_load = 1'b1;
          if (fits) begin
            state_nxt = ST_WR_HI;
          end else begin
            drop_inc  = 1'b1;
            state_nxt = ST_DROP;
          end
        end
      end
      ST_WR_HI: begin
        if (!mem_wr_full) begin
          wr_now    = 1'b1;
          wr_sel    = SEL_HOLD_HI;
          state_nxt = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (!mem_wr_full) begin
          wr_now    = 1'b1;
          wr_sel    = SEL_HOLD_LO;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!fifo_empty && !mem_wr_full) begin
          pop     = 1'b1;
          wr_now  = 1'b1;
          rem_dec = 1'b1;
          if (remaining == 13'd1) begin
            pkt_inc   = 1'b1;
            state_nxt = ST_HDR_HI;
          end
        end
      end
      ST_DROP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rem_dec = 1'b1;
          if (remaining == 13'd1) begin
            state_nxt = ST_HDR_HI;
          end
        end
      end
      default: state_nxt = ST_HDR_HI;
    endcase
  end

  // No pops while either reset is applied, so the FIFO and the parser stay
  // aligned on packet boundaries when both sides come out of reset.
  assign fifo_rd_en = pop && axi_aresetn && !sw_rst;

  // FSM state, header holding registers, remaining-word counter and the
  // registered memory write port.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= ST_HDR_HI;
      hold_hi     <= '0;
      hold_lo     <= '0;
      cur_qid     <= '0;
      remaining   <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (sw_rst) begin
      state       <= ST_HDR_HI;
      hold_hi     <= '0;
      hold_lo     <= '0;
      cur_qid     <= '0;
      remaining   <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (hi_load) begin
        hold_hi <= fifo_dout;
        cur_qid <= fifo_dout_qid;
      end
      if (lo_load) begin
        hold_lo <= fifo_dout;
      end
      if (rem_load) begin
        remaining <= {beats, 1'b0};
      end else if (rem_dec) begin
        remaining <= remaining - 13'd1;
      end
      mem_wr_en <= wr_now;
      if (wr_now) begin
        mem_wr_addr <= cur_ptr;
        case (wr_sel)
          SEL_HOLD_HI: mem_wr_data <= hold_hi;
          SEL_HOLD_LO: mem_wr_data <= hold_lo;
          default:     mem_wr_data <= fifo_dout;
        endcase
      end
    end
  end

  pcap_mem_qptr_bank #(
    .NUM_QUEUES      (NUM_QUEUES),
    .NUM_QUEUES_BITS (NUM_QUEUES_BITS),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_qptr_bank (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .sw_rst      (sw_rst),
    .q_base_addr (q_base_addr),
    .q_ptr_clr   (q_ptr_clr),
    .qid         (cur_qid),
    .ptr_inc     (wr_now),
    .pkt_inc     (pkt_inc),
    .drop_inc    (drop_inc),
    .q_wr_ptr    (q_wr_ptr),
    .q_pkt_cnt   (q_pkt_cnt),
    .q_drop_cnt  (q_drop_cnt)
  );

endmodule

// File: tb/tb_pcap_mem_writer.sv
// tb_pcap_mem_writer
// Randomised bench for pcap_mem_writer. A queue stands in for the FWFT FIFO,
// a per-packet reference model predicts every memory write (address, word)
// and the per-queue pointers and counters from the packet length and the
// region limits.
module tb_pcap_mem_writer;

  localparam int W  = 144;
  localparam int NQ = 4;
  localparam int QB = 2;
  localparam int AW = 19;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic              sw_rst = 1'b0;
  logic [W-1:0]      fifo_dout = '0;
  logic [QB-1:0]     fifo_dout_qid = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [W-1:0]      mem_wr_data;
  logic              mem_wr_full = 1'b0;
  logic              wr_enable = 1'b1;
  logic [NQ*AW-1:0]  q_base_addr = '0;
  logic [NQ*AW-1:0]  q_high_addr = '0;
  logic [NQ-1:0]     q_ptr_clr = '0;
  logic [NQ*AW-1:0]  q_wr_ptr;
  logic [NQ*32-1:0]  q_pkt_cnt;
  logic [NQ*32-1:0]  q_drop_cnt;

  always #5 axi_aclk = ~axi_aclk;

  pcap_mem_writer #(
    .FIFO_DATA_WIDTH (W),
    .NUM_QUEUES      (NQ),
    .NUM_QUEUES_BITS (QB),
    .ADDR_WIDTH      (AW),
    .LEN_POS         (0)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .sw_rst        (sw_rst),
    .fifo_dout     (fifo_dout),
    .fifo_dout_qid (fifo_dout_qid),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_full   (mem_wr_full),
    .wr_enable     (wr_enable),
    .q_base_addr   (q_base_addr),
    .q_high_addr   (q_high_addr),
    .q_ptr_clr     (q_ptr_clr),
    .q_wr_ptr      (q_wr_ptr),
    .q_pkt_cnt     (q_pkt_cnt),
    .q_drop_cnt    (q_drop_cnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [QB-1:0] qid;
  } fw_t;

  int numCompared = 0;
  int numMismatched = 0;

  wr_t expQ[$];
  fw_t tbFifo[$];

  int          baseAddr[NQ];
  int          highAddr[NQ];
  int          mPtr[NQ];
  int unsigned mPkt[NQ];
  int unsigned mDrop[NQ];

  int fullMode = 0;
  bit fifoBubbles = 1'b0;
  bit wrEnRandom = 1'b0;
  bit fullPhase = 1'b0;
  int wrSeen = 0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] packWord(input logic [127:0] d, input logic [15:0] s);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[9*i +: 9] = {s[i], d[8*i +: 8]};
    end
    return w;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model reset: pointers back at base, counters cleared, nothing pending.
  task automatic resetModel();
    tbFifo.delete();
    expQ.delete();
    for (int q = 0; q < NQ; q++) begin
      mPtr[q]  = baseAddr[q];
      mPkt[q]  = 0;
      mDrop[q] = 0;
    end
  endtask

  // Queue one packet into the FIFO stand-in and predict its outcome.
  task automatic applyStimulus(input int q, input int len);
    int           beats;
    int           words;
    logic [127:0] d;
    logic [15:0]  s;
    logic [W-1:0] pkt[$];
    beats = (len == 0) ? 1 : (len + 31) / 32;
    words = 2 + 2 * beats;
    pkt.push_back(packWord('0, '0));
    d = rand128();
    d[15:0] = 16'(len);
    pkt.push_back(packWord(d, 16'hFFFF));
    for (int b = 0; b < beats; b++) begin
      for (int h = 0; h < 2; h++) begin
        int first;
        first = b * 32 + ((h == 0) ? 16 : 0);
        for (int k = 0; k < 16; k++) begin
          s[k] = ((first + k) < len);
        end
        pkt.push_back(packWord(rand128(), s));
      end
    end
    foreach (pkt[i]) begin
      tbFifo.push_back('{data: pkt[i], qid: QB'(q)});
    end
    if (mPtr[q] + words - 1 <= highAddr[q]) begin
      foreach (pkt[i]) begin
        expQ.push_back('{addr: AW'(mPtr[q] + i), data: pkt[i]});
      end
      mPtr[q] += words;
      mPkt[q]++;
    end else begin
      mDrop[q]++;
    end
  endtask

  task automatic checkQueues(input string tag);
    for (int q = 0; q < NQ; q++) begin
      checkOutput($sformatf("%s_ptr%0d", tag, q), W'(q_wr_ptr[q*AW +: AW]), W'(mPtr[q]));
      checkOutput($sformatf("%s_pkt%0d", tag, q), W'(q_pkt_cnt[q*32 +: 32]), W'(mPkt[q]));
      checkOutput($sformatf("%s_drop%0d", tag, q), W'(q_drop_cnt[q*32 +: 32]), W'(mDrop[q]));
    end
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while ((tbFifo.size() != 0 || expQ.size() != 0) && n < budget) begin
      @(posedge axi_aclk);
      n++;
    end
    repeat (6) @(posedge axi_aclk);
    checkOutput({tag, "_drained"}, W'(n < budget), W'(1));
    #2;
    checkQueues(tag);
  endtask

  // FIFO stand-in and write monitor: inputs change just after the rising
  // edge; pops and writes are observed on the falling edge.
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      fullPhase = ~fullPhase;
      case (fullMode)
        1:       mem_wr_full = fullPhase;
        2:       mem_wr_full = ($urandom_range(0, 3) == 0);
        default: mem_wr_full = 1'b0;
      endcase
      wr_enable = wrEnRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (tbFifo.size() > 0 && !(fifoBubbles && $urandom_range(0, 3) == 0)) begin
        fifo_empty    = 1'b0;
        fifo_dout     = tbFifo[0].data;
        fifo_dout_qid = tbFifo[0].qid;
      end else begin
        fifo_empty    = 1'b1;
        fifo_dout     = '0;
        fifo_dout_qid = '0;
      end
      @(negedge axi_aclk);
      if (fifo_rd_en) begin
        if (fifo_empty || tbFifo.size() == 0) begin
          checkOutput("popWhileEmpty", W'(fifo_rd_en), W'(0));
        end else begin
          void'(tbFifo.pop_front());
        end
      end
      if (mem_wr_en) begin
        wrSeen++;
        if (expQ.size() == 0) begin
          checkOutput("spuriousWrite", W'(mem_wr_en), W'(0));
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("wrAddr", W'(mem_wr_addr), W'(e.addr));
          checkOutput("wrData", mem_wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    baseAddr = '{32'h100, 32'h200, 32'h300, 32'h400};
    highAddr = '{32'h1FF, 32'h203, 32'h3FF, 32'h7FF};
    for (int q = 0; q < NQ; q++) begin
      q_base_addr[q*AW +: AW] = AW'(baseAddr[q]);
      q_high_addr[q*AW +: AW] = AW'(highAddr[q]);
    end
    resetModel();

    // Reset state
    repeat (3) @(posedge axi_aclk);
    #2;
    checkOutput("rst_wrEn", W'(mem_wr_en), W'(0));
    checkOutput("rst_wrAddr", W'(mem_wr_addr), W'(0));
    checkOutput("rst_wrData", mem_wr_data, W'(0));
    checkOutput("rst_rdEn", W'(fifo_rd_en), W'(0));
    checkQueues("rst");
    axi_aresetn = 1'b1;
    repeat (2) @(posedge axi_aclk);
    #2;

    // 64-byte packet on q0: six words from 0x100
    applyStimulus(0, 64);
    waitDrain("q0_64", 500);

    // Rounding: 33 bytes is two beats, zero bytes is one beat
    applyStimulus(2, 33);
    applyStimulus(2, 0);
    waitDrain("q2_len", 500);

    // q1 has four free words: 64 bytes dropped, then 1 byte fits exactly
    applyStimulus(1, 64);
    waitDrain("q1_drop", 500);
    applyStimulus(1, 1);
    waitDrain("q1_fit", 500);

    // Write-full toggling every other cycle during payload
    fullMode = 1;
    applyStimulus(0, 200);
    applyStimulus(2, 96);
    waitDrain("full_tog", 1000);
    fullMode = 0;

    // Back-to-back packets on two queues
    applyStimulus(0, 64);
    applyStimulus(3, 64);
    applyStimulus(0, 17);
    applyStimulus(3, 128);
    waitDrain("interleave", 1000);

    // Pointer reload on q1
    @(posedge axi_aclk);
    #2;
    q_ptr_clr = 4'b0010;
    @(posedge axi_aclk);
    #2;
    q_ptr_clr = '0;
    mPtr[1] = baseAddr[1];
    checkOutput("clr_ptr1", W'(q_wr_ptr[1*AW +: AW]), W'(baseAddr[1]));

    // Random traffic with bubbles, stalls and hold-offs
    fullMode = 2;
    fifoBubbles = 1'b1;
    wrEnRandom = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, NQ - 1), $urandom_range(0, 300));
    end
    waitDrain("random", 20000);
    fullMode = 0;
    fifoBubbles = 1'b0;
    wrEnRandom = 1'b0;

    // Async reset in the middle of payload, then a clean packet
    wrSeen = 0;
    applyStimulus(3, 256);
    n = 0;
    while (wrSeen < 5 && n < 200) begin
      @(posedge axi_aclk);
      n++;
    end
    checkOutput("midpkt_reached", W'(wrSeen >= 5), W'(1));
    @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b0;
    resetModel();
    #1;
    checkOutput("arst_wrEn", W'(mem_wr_en), W'(0));
    checkOutput("arst_wrAddr", W'(mem_wr_addr), W'(0));
    checkOutput("arst_wrData", mem_wr_data, W'(0));
    checkOutput("arst_rdEn", W'(fifo_rd_en), W'(0));
    checkQueues("arst");
    repeat (3) @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b1;
    applyStimulus(3, 64);
    waitDrain("post_arst", 500);

    // Soft reset clears pointers and counters
    @(posedge axi_aclk);
    #2;
    sw_rst = 1'b1;
    @(posedge axi_aclk);
    #2;
    sw_rst = 1'b0;
    resetModel();
    checkQueues("swrst");
    applyStimulus(0, 40);
    waitDrain("post_swrst", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
